adc_seq_ctrl: RTL and testbench

- Sequencer for the LTC2308-style SPI ADC that feeds the FIR, CIC and IIR filter chain.
- Generates CONVST, SCK and the SDI config word at a fixed sample rate, and deserialises the 12-bit SDO result.
- Converts each result to a 16-bit signed sample with a one-cycle valid strobe and a channel tag.
- Replaces the raw SDO bit wiring into the filters with sample-rate-qualified parallel data.

---
 rtl/adc_seq_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_adc_seq_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_seq_ctrl.sv
// SPI ADC sequencer: CONVST/SCK/SDI generation at a fixed sample rate, 12-bit SDO capture, signed sample out.
// Strobe lands CONV_CYCLES + 24*CLK_DIV + 1 cycles after each CONVST rise; no backpressure, output is a pulse.
module adc_seq_ctrl #(
  parameter int CLK_DIV       = 2,
  parameter int CONV_CYCLES   = 80,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int OUT_WIDTH     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [2:0]           i_channel,
  output logic                 o_adc_convst,
  output logic                 o_adc_sck,
  output logic                 o_adc_sdi,
  input  logic                 i_adc_sdo,
  output logic [OUT_WIDTH-1:0] o_sample,
  output logic                 o_sample_valid,
  output logic [2:0]           o_channel_tag,
  output logic                 o_busy
);

  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_SHIFT,
    S_DONE,
    S_WAIT
  } state_t;

  state_t                 state_q;
  logic [PW-1:0]          per_q;
  logic [CW-1:0]          conv_q;
  logic [DW-1:0]          div_q;
  logic [3:0]             bit_q;
  logic                   convst_q;
  logic                   sck_q;
  logic                   sdi_q;
  logic [11:0]            cfg_sr_q;
  logic [2:0]             cfg_ch_q;
  logic [2:0]             prev_ch_q;
  logic [11:0]            data_q;
  logic [OUT_WIDTH-1:0]   sample_q;
  logic [OUT_WIDTH-1:0]   sample_d;
  logic                   valid_q;
  logic [2:0]             tag_q;
  logic                   busy_q;
  logic                   prime_q;
  logic                   per_wrap;
  logic [11:0]            code_ofs;

  // Config word as shifted out, first bit in [11]: S/D, ODD, SEL1, SEL0, UNI, SLP, then zeros.
  function automatic logic [11:0] cfg_word(input logic [2:0] ch);
    return {1'b1, ch[0], ch[2], ch[1], 1'b1, 7'b0};
  endfunction

  assign per_wrap = (per_q == PW'(SAMPLE_PERIOD - 1));

  // Offset-binary to two's complement is an MSB flip; the left shift just pads zeros below.
  assign code_ofs = {~data_q[11], data_q[10:0]};

  generate
    if (OUT_WIDTH > 12) begin : g_wide
      assign sample_d = {code_ofs, {(OUT_WIDTH-12){1'b0}}};
    end else begin : g_narrow
      assign sample_d = code_ofs;
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      per_q     <= '0;
      conv_q    <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      convst_q  <= 1'b0;
      sck_q     <= 1'b0;
      sdi_q     <= 1'b0;
      cfg_sr_q  <= '0;
      cfg_ch_q  <= '0;
      prev_ch_q <= '0;
      data_q    <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      tag_q     <= '0;
      busy_q    <= 1'b0;
      prime_q   <= 1'b1;
    end else begin
      valid_q <= 1'b0;
      if (state_q != S_IDLE) begin
        per_q <= per_wrap ? '0 : per_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (i_enable) begin
            state_q  <= S_CONV;
            convst_q <= 1'b1;
            busy_q   <= 1'b1;
            conv_q   <= '0;
            per_q    <= '0;
          end
        end

        S_CONV: begin
          if (conv_q == CW'(CONV_CYCLES - 1)) begin
            state_q  <= S_SHIFT;
            convst_q <= 1'b0;
            cfg_ch_q <= i_channel;
            cfg_sr_q <= cfg_word(i_channel);
            sdi_q    <= 1'b1;
            sck_q    <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
          end else begin
            conv_q <= conv_q + 1'b1;
          end
        end

        S_SHIFT: begin
          if (div_q != DW'(CLK_DIV - 1)) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q <= '0;
            if (!sck_q) begin
              sck_q  <= 1'b1;
              data_q <= {data_q[10:0], i_adc_sdo};
            end else begin
              sck_q <= 1'b0;
              if (bit_q == 4'd11) begin
                state_q <= S_DONE;
                sdi_q   <= 1'b0;
              end else begin
                bit_q    <= bit_q + 1'b1;
                cfg_sr_q <= {cfg_sr_q[10:0], 1'b0};
                sdi_q    <= cfg_sr_q[10];
              end
            end
          end
        end

        S_DONE: begin
          // The ADC answers with the previous frame's channel.
          if (!prime_q) begin
            valid_q  <= 1'b1;
            sample_q <= sample_d;
            tag_q    <= prev_ch_q;
          end
          prev_ch_q <= cfg_ch_q;
          if (i_enable) begin
            state_q <= S_WAIT;
            prime_q <= 1'b0;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            prime_q <= 1'b1;
          end
        end

        S_WAIT: begin
          if (per_wrap) begin
            if (i_enable) begin
              state_q  <= S_CONV;
              convst_q <= 1'b1;
              conv_q   <= '0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              prime_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          prime_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_adc_convst   = convst_q;
  assign o_adc_sck      = sck_q;
  assign o_adc_sdi      = sdi_q;
  assign o_sample       = sample_q;
  assign o_sample_valid = valid_q;
  assign o_channel_tag  = tag_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Directed bench for adc_seq_ctrl with a behavioural ADC that plays back a 12-bit code per frame.
module tb_adc_seq_ctrl;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic [2:0]  i_channel;
  logic        i_adc_sdo;
  logic        o_adc_convst;
  logic        o_adc_sck;
  logic        o_adc_sdi;
  logic [15:0] o_sample;
  logic        o_sample_valid;
  logic [2:0]  o_channel_tag;
  logic        o_busy;

  int vectors = 0;
  int miscompares = 0;

  // ADC model / monitor state
  int          cyc = 0;
  int          conv_rises = 0;
  int          conv_rise_cyc = -1;
  int          conv_cnt = 0;
  int          conv_len = 0;
  int          frame_sck = 0;
  int          valid_cnt = 0;
  logic [11:0] sdi_word = '0;
  logic [11:0] adc_code = '0;
  logic        cv_prev = 1'b0;
  logic        sck_prev = 1'b0;

  adc_seq_ctrl #(
    .CLK_DIV(2), .CONV_CYCLES(4), .SAMPLE_PERIOD(64), .OUT_WIDTH(16)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_channel(i_channel),
    .o_adc_convst(o_adc_convst), .o_adc_sck(o_adc_sck), .o_adc_sdi(o_adc_sdi),
    .i_adc_sdo(i_adc_sdo), .o_sample(o_sample), .o_sample_valid(o_sample_valid),
    .o_channel_tag(o_channel_tag), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (o_adc_convst === 1'b1 && cv_prev !== 1'b1) begin
      conv_rises    = conv_rises + 1;
      conv_rise_cyc = cyc;
      conv_cnt      = 1;
      frame_sck     = 0;
      sdi_word      = '0;
    end else if (o_adc_convst === 1'b1) begin
      conv_cnt = conv_cnt + 1;
    end else if (cv_prev === 1'b1) begin
      conv_len = conv_cnt;
    end
    if (o_adc_sck === 1'b1 && sck_prev !== 1'b1) begin
      frame_sck = frame_sck + 1;
      sdi_word  = {sdi_word[10:0], o_adc_sdi};
    end
    if (o_sample_valid === 1'b1) valid_cnt = valid_cnt + 1;
    i_adc_sdo = (frame_sck < 12) ? adc_code[11 - frame_sck] : 1'b0;
    cv_prev  = o_adc_convst;
    sck_prev = o_adc_sck;
  end

  initial begin
    #100us;
    $display("FAIL watchdog: time limit reached, %0d vectors applied", vectors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_enable = 1'b0; i_channel = 3'd0;
    repeat (3) tick();
    vectors++;
    if ({o_adc_convst, o_adc_sck, o_adc_sdi, o_sample_valid, o_busy} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b want 00000",
               {o_adc_convst, o_adc_sck, o_adc_sdi, o_sample_valid, o_busy});
    end
    vectors++;
    if (o_sample !== 16'h0 || o_channel_tag !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_dat: sample %h tag %0d want 0/0", o_sample, o_channel_tag);
    end
    i_reset = 1'b0;
    repeat (3) tick();
    vectors++;
    if (o_busy !== 1'b0 || o_adc_convst !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_enable: busy %b convst %b want 0/0", o_busy, o_adc_convst);
    end
  endtask

  // Raise enable and expect CONVST on the very next edge.
  task automatic wait_rise(input string nm);
    int c;
    int r0;
    bit seen;
    c = cyc; r0 = conv_rises; seen = 0;
    i_enable = 1'b1;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (conv_rises != r0) seen = 1;
    end
    vectors++;
    if (!seen || conv_rise_cyc != c + 1) begin
      miscompares++;
      $display("FAIL %s_start: convst rise at %0d (seen %0d) want %0d", nm, conv_rise_cyc, seen, c + 1);
    end
  endtask

  // Called on the cycle CONVST first reads high; returns on the next frame's rise cycle.
  task automatic run_frame(input string nm, input logic [11:0] code, input bit exp_vld,
                           input logic [15:0] exp_smp, input logic [2:0] exp_tag,
                           input logic [11:0] exp_sdi, input int new_ch, input bit drop_en,
                           input bit exp_next);
    int t0;
    int r0;
    int v0;
    t0 = conv_rise_cyc; r0 = conv_rises; v0 = valid_cnt;
    adc_code = code;
    for (int off = 1; off <= 64; off++) begin
      tick();
      if (off == 10 && new_ch >= 0) i_channel = 3'(new_ch);
      if (off == 20 && drop_en) i_enable = 1'b0;
      if (off == 30) begin
        vectors++;
        if (o_busy !== 1'b1) begin
          miscompares++;
          $display("FAIL %s_busy: got %b want 1", nm, o_busy);
        end
      end
      if (off == 52) begin
        vectors++;
        if (o_sample_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL %s_early_valid: got %b at t0+52 want 0", nm, o_sample_valid);
        end
      end
      if (off == 53) begin
        vectors++;
        if (o_sample_valid !== exp_vld) begin
          miscompares++;
          $display("FAIL %s_valid: got %b at t0+53 want %b", nm, o_sample_valid, exp_vld);
        end
        vectors++;
        if (o_sample !== exp_smp) begin
          miscompares++;
          $display("FAIL %s_sample: got %0d want %0d", nm, $signed(o_sample), $signed(exp_smp));
        end
        if (exp_vld) begin
          vectors++;
          if (o_channel_tag !== exp_tag) begin
            miscompares++;
            $display("FAIL %s_tag: got %0d want %0d", nm, o_channel_tag, exp_tag);
          end
        end
        vectors++;
        if (sdi_word !== exp_sdi) begin
          miscompares++;
          $display("FAIL %s_sdi: got %b want %b", nm, sdi_word, exp_sdi);
        end
        vectors++;
        if (conv_len != 4 || o_adc_sck !== 1'b0) begin
          miscompares++;
          $display("FAIL %s_convst_len: got %0d sck %b want 4 / 0", nm, conv_len, o_adc_sck);
        end
      end
      if (off == 63) begin
        vectors++;
        if (frame_sck != 12) begin
          miscompares++;
          $display("FAIL %s_sck_count: got %0d want 12", nm, frame_sck);
        end
      end
    end
    vectors++;
    if (exp_next) begin
      if (conv_rises != r0 + 1 || conv_rise_cyc != t0 + 64) begin
        miscompares++;
        $display("FAIL %s_period: next rise at %0d want %0d", nm, conv_rise_cyc, t0 + 64);
      end
    end else begin
      if (conv_rises != r0 || o_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_idle: rises %0d busy %b want %0d / 0", nm, conv_rises, o_busy, r0);
      end
    end
    vectors++;
    if (valid_cnt - v0 != (exp_vld ? 1 : 0)) begin
      miscompares++;
      $display("FAIL %s_strobe_count: got %0d want %0d", nm, valid_cnt - v0, exp_vld ? 1 : 0);
    end
  endtask

  task automatic test_priming();
    i_channel = 3'd3;
    wait_rise("prime");
    run_frame("f1_prime", 12'h5A5, 1'b0, 16'h0000, 3'd0, 12'hD80, -1, 1'b0, 1'b1);
  endtask

  task automatic test_continuous();
    run_frame("f2_fff", 12'hFFF, 1'b1, 16'h7FF0, 3'd3, 12'hD80, -1, 1'b0, 1'b1);
    run_frame("f3_000", 12'h000, 1'b1, 16'h8000, 3'd3, 12'hD80,  5, 1'b0, 1'b1);
    run_frame("f4_800", 12'h800, 1'b1, 16'h0000, 3'd3, 12'hE80, -1, 1'b0, 1'b1);
  endtask

  task automatic test_channel_and_saturation();
    run_frame("f5_hi", 12'hFFF, 1'b1, 16'h7FF0, 3'd5, 12'hE80, -1, 1'b0, 1'b1);
    run_frame("f6_lo", 12'h000, 1'b1, 16'h8000, 3'd5, 12'hE80, -1, 1'b0, 1'b1);
  endtask

  task automatic test_enable_drop();
    run_frame("f7_drop", 12'hFFF, 1'b1, 16'h7FF0, 3'd5, 12'hE80, -1, 1'b1, 1'b0);
    wait_rise("reenable");
    run_frame("f8_prime", 12'h123, 1'b0, 16'h7FF0, 3'd0, 12'hE80, -1, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midframe();
    int v0;
    v0 = valid_cnt;
    adc_code = 12'hABC;
    for (int off = 1; off <= 60; off++) begin
      tick();
      if (off == 30) begin
        i_reset = 1'b1;
        i_enable = 1'b0;
      end
      if (off == 31) begin
        vectors++;
        if ({o_adc_convst, o_adc_sck, o_adc_sdi, o_sample_valid, o_busy} !== 5'b0 ||
            o_sample !== 16'h0 || o_channel_tag !== 3'd0) begin
          miscompares++;
          $display("FAIL midreset_outputs: ctl %b sample %h tag %0d want all 0",
                   {o_adc_convst, o_adc_sck, o_adc_sdi, o_sample_valid, o_busy},
                   o_sample, o_channel_tag);
        end
        i_reset = 1'b0;
      end
    end
    vectors++;
    if (valid_cnt != v0 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_no_strobe: strobes %0d busy %b want 0 / 0", valid_cnt - v0, o_busy);
    end
    wait_rise("postreset");
    run_frame("f10_prime", 12'h7FF, 1'b0, 16'h0000, 3'd0, 12'hE80, -1, 1'b0, 1'b1);
    run_frame("f11_801",   12'h801, 1'b1, 16'h0010, 3'd5, 12'hE80, -1, 1'b0, 1'b1);
  endtask

  initial begin
    i_reset = 1'b1; i_enable = 1'b0; i_channel = 3'd0; i_adc_sdo = 1'b0;
    test_reset();
    test_priming();
    test_continuous();
    test_channel_and_saturation();
    test_enable_drop();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
